pipe_stage_slice: RTL and testbench
===================================

# pipe_stage_slice

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, flush-to-bubble and stall/flush statistics. It is the generalised successor to the fixed-field inter-stage registers: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own control and datapath widths. Back-pressure replaces the global stall enable, so a downstream stall never drops or duplicates an instruction. A flush inserts a bubble whose control field is a parameter, so no write-enable or branch bit can leak through.

## Interface
- CTRL_W, default 12: width of the control bundle (ResultSrc, MemWrite, RegWrite, Jump, Branch, …).
- DATA_W, default 128: width of the datapath bundle (PC, PC+4, operands, immediate, register indices).
- BUBBLE_CTRL, default {CTRL_W{1'b0}}: control value presented whenever the stage holds no valid entry.
- CNT_W, default 16: width of the statistics counters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  discard all held entries this cycle (synchronous).
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream datapath bundle.
- out_valid  out  1  main register holds a valid entry.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_ctrl  out  CTRL_W  main-register control; BUBBLE_CTRL whenever out_valid=0.
- out_data  out  DATA_W  main-register data; 0 after reset or flush.
- occ  out  2  occupancy: 0, 1 or 2 entries.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
- flush_cnt  out  CNT_W  cycles with flush=1; saturating.

## Operation
- Storage: a main register (main_valid, ctrl, data) drives the outputs. A skid register (skid_valid, ctrl, data) holds one overflow entry.
- A transfer in happens when in_valid && in_ready. A transfer out happens when out_valid && out_ready.
- EMPTY (occ=0):
  - transfer in → main <= in; go to ONE.
- ONE (occ=1):
  - in and out → main <= in; stay in ONE.
  - in only → skid <= in; go to FULL.
  - out only → main_valid <= 0 and main ctrl <= BUBBLE_CTRL; go to EMPTY. Data is held.
  - neither → hold.
- FULL (occ=2): in_ready=0.
  - out → main <= skid and skid_valid <= 0; go to ONE.
  - no out → hold.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- flush=1:
  - Next state is EMPTY from any state.
  - main ctrl <= BUBBLE_CTRL; main and skid data <= 0; both valid bits <= 0.
  - in_valid is ignored that cycle, even when in_ready=1. The upstream stage is flushed by the same hazard unit.
  - A transfer out in the same cycle still counts as completed downstream.
- Counters:
  - Each increments by 1 when its condition holds and saturates at 2^CNT_W−1.
  - Flush does not clear the counters; only reset does.
- Reset: main_valid=0, skid_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1, out_valid=0, occ=0, stall_cnt=0, flush_cnt=0.

## Timing
- Latency: 1 cycle. An entry accepted at edge N is on out_* after edge N with out_valid=1.
- Throughput: 1 entry/cycle when out_ready is held at 1; the skid entry is never used in that case.
- in_ready depends only on state, never combinationally on out_ready, which breaks the ready path.
- Recovery from FULL: in_ready returns to 1 one cycle after the out_ready that drains the skid entry.
- Flush: out_valid=0 and out_ctrl=BUBBLE_CTRL on the cycle after the flush edge; in_ready=1 on that same cycle.
- Reset: takes effect asynchronously on the falling edge of rst and releases synchronously to clk. The first accept can occur at the first rising edge with rst=1.

## Test plan
- Streaming, out_ready=1: send 4 entries with ctrl 0x001…0x004 on consecutive cycles → they appear one cycle later in order, occ never exceeds 1, stall_cnt=0.
- Back-pressure:
  - Stimulus: send A then B while out_ready=0.
  - Required while stalled: occ=2, in_ready=0 from the cycle after B, out_ctrl=A held, stall_cnt counts each stalled cycle (3 after 3 cycles).
  - Release out_ready → A then B delivered on consecutive cycles, no loss, no duplication.
- Flush in FULL with in_valid=1, entry C → next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occ=0, C dropped, flush_cnt=1.
- Counter saturation, CNT_W=4: hold a stall for 20 cycles → stall_cnt sticks at 15.
- Reset mid-operation: assert rst=0 asynchronously while FULL → outputs reach their reset values before the next clock edge. After release, the first entry has 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_slice.sv
// rtl/pipe_stage_slice.sv - pipeline stage register with valid/ready handshake, one-entry skid buffer and flush
// Occupancy doubles as the FSM state; the skid entry only fills when downstream stalls.
module pipe_stage_slice #(
  parameter int                 CTRL_W      = 12,
  parameter int                 DATA_W      = 128,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                xfer_in;
  logic                xfer_out;

  // in_ready comes from state only, so out_ready never reaches it combinationally.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occ       = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign xfer_in  = in_valid && in_ready && !flush;
  assign xfer_out = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_data_d = '0;
      skid_ctrl_d = BUBBLE_CTRL;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (xfer_in) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (xfer_out) begin
            main_ctrl_d = BUBBLE_CTRL;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = BUBBLE_CTRL;
        end
      endcase
    end
  end

  // Saturating statistics; flush leaves them untouched.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_slice.sv
// tb/tb_pipe_stage_slice.sv - table-driven bench for pipe_stage_slice
module tb_pipe_stage_slice;

  localparam int CTRL_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [CTRL_W-1:0] BUBBLE = 12'hA5A;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_slice #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [CTRL_W-1:0] ic;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              fl;
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
    logic [1:0]        eocc;
    logic              erdy;
    logic [CNT_W-1:0]  es;
    logic [CNT_W-1:0]  ef;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [CTRL_W-1:0] ec,
                           input logic [DATA_W-1:0] ed, input logic [1:0] eocc, input logic erdy,
                           input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, " out_ctrl"},  32'(out_ctrl),  32'(ec));
    check({tag, " out_data"},  32'(out_data),  32'(ed));
    check({tag, " occ"},       32'(occ),       32'(eocc));
    check({tag, " in_ready"},  32'(in_ready),  32'(erdy));
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(es));
    check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(ef));
  endtask

  initial begin
    //         iv  ic      id        ordy fl   ev  ec      ed        occ rdy st fl
    vecs[0]  = '{1, 12'h001, 16'h1001, 1, 0,  1, 12'h001, 16'h1001, 1, 1, 0, 0};
    vecs[1]  = '{1, 12'h002, 16'h1002, 1, 0,  1, 12'h002, 16'h1002, 1, 1, 0, 0};
    vecs[2]  = '{1, 12'h003, 16'h1003, 1, 0,  1, 12'h003, 16'h1003, 1, 1, 0, 0};
    vecs[3]  = '{1, 12'h004, 16'h1004, 1, 0,  1, 12'h004, 16'h1004, 1, 1, 0, 0};
    vecs[4]  = '{0, 12'h000, 16'h0000, 1, 0,  0, BUBBLE,  16'h1004, 0, 1, 0, 0};
    vecs[5]  = '{1, 12'h0A1, 16'h20A1, 0, 0,  1, 12'h0A1, 16'h20A1, 1, 1, 0, 0};
    vecs[6]  = '{1, 12'h0B2, 16'h20B2, 0, 0,  1, 12'h0A1, 16'h20A1, 2, 0, 1, 0};
    vecs[7]  = '{1, 12'h0CC, 16'h20CC, 0, 0,  1, 12'h0A1, 16'h20A1, 2, 0, 2, 0};
    vecs[8]  = '{0, 12'h000, 16'h0000, 0, 0,  1, 12'h0A1, 16'h20A1, 2, 0, 3, 0};
    vecs[9]  = '{0, 12'h000, 16'h0000, 1, 0,  1, 12'h0B2, 16'h20B2, 1, 1, 3, 0};
    vecs[10] = '{0, 12'h000, 16'h0000, 1, 0,  0, BUBBLE,  16'h20B2, 0, 1, 3, 0};
    vecs[11] = '{1, 12'h0D1, 16'h30D1, 0, 0,  1, 12'h0D1, 16'h30D1, 1, 1, 3, 0};
    vecs[12] = '{1, 12'h0E2, 16'h30E2, 0, 0,  1, 12'h0D1, 16'h30D1, 2, 0, 4, 0};
    vecs[13] = '{1, 12'h0C3, 16'h40C3, 0, 1,  0, BUBBLE,  16'h0000, 0, 1, 5, 1};
    vecs[14] = '{1, 12'h0F4, 16'h50F4, 1, 0,  1, 12'h0F4, 16'h50F4, 1, 1, 5, 1};
    vecs[15] = '{0, 12'h000, 16'h0000, 1, 0,  0, BUBBLE,  16'h50F4, 0, 1, 5, 1};
    vecs[16] = '{1, 12'h011, 16'h6011, 0, 0,  1, 12'h011, 16'h6011, 1, 1, 5, 1};
    vecs[17] = '{0, 12'h000, 16'h0000, 1, 1,  0, BUBBLE,  16'h0000, 0, 1, 5, 2};
    vecs[18] = '{1, 12'h021, 16'h6021, 1, 0,  1, 12'h021, 16'h6021, 1, 1, 5, 2};
    vecs[19] = '{1, 12'h022, 16'h6022, 1, 0,  1, 12'h022, 16'h6022, 1, 1, 5, 2};
    vecs[20] = '{0, 12'h000, 16'h0000, 0, 0,  1, 12'h022, 16'h6022, 1, 1, 6, 2};
    vecs[21] = '{0, 12'h000, 16'h0000, 1, 0,  0, BUBBLE,  16'h6022, 0, 1, 6, 2};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, BUBBLE, 16'h0000, 2'd0, 1'b1, 4'd0, 4'd0);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ed,
                vecs[i].eocc, vecs[i].erdy, vecs[i].es, vecs[i].ef);
    end

    // Stall counter saturation at 15 with a 4-bit counter.
    drive(1'b1, 12'h031, 16'h7031, 1'b0, 1'b0);
    check("sat load occ", 32'(occ), 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    check("sat mid stall_cnt", 32'(stall_cnt), 32'd11);
    for (int i = 0; i < 15; i++) drive(1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    check("sat stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat out_ctrl", 32'(out_ctrl), 32'h031);

    // Fill to FULL, then reset asynchronously between clock edges.
    drive(1'b1, 12'h041, 16'h7041, 1'b0, 1'b0);
    check("pre-reset occ", 32'(occ), 32'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all("async reset", 1'b0, BUBBLE, 16'h0000, 2'd0, 1'b1, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 12'h051, 16'h8051, 1'b1, 1'b0);
    check_all("post-reset accept", 1'b1, 12'h051, 16'h8051, 2'd1, 1'b1, 4'd0, 4'd0);
    drive(1'b0, 12'h000, 16'h0000, 1'b1, 1'b0);
    check_all("post-reset drain", 1'b0, BUBBLE, 16'h8051, 2'd0, 1'b1, 4'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
